// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch (SS.hh, 00.00..59.99) with run/stop, lap hold and clear.
// The selected digit is returned combinationally for the downstream display scan.
module stopwatch_bcd #(
    parameter int DIV = 1000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    input  logic [1:0] digit_idx,
    output logic [3:0] stopwatch,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    // state | meaning
    // IDLE  | cleared, not counting
    // RUN   | counting, display shows live count
    // LAP   | counting, display frozen on lap register
    // STOP  | halted, count and prescaler held
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] LAP  = 2'd2;
    localparam logic [1:0] STOP = 2'd3;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PW-1:0]    prescaler;
    logic [3:0][3:0]  cnt;
    logic [3:0][3:0]  inc;
    logic [3:0][3:0]  lap_reg;
    logic             wrap;
    logic             counting;
    logic             tick;
    logic             clr_now;
    logic             capture;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (prescaler == PMAX);
    assign clr_now  = (state == STOP) && !start_stop && clear;
    assign capture  = (state == RUN) && !start_stop && lap;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_stop) state_nxt = RUN;
            RUN: begin
                if (start_stop) state_nxt = STOP;
                else if (lap)   state_nxt = LAP;
            end
            LAP: begin
                if (start_stop) state_nxt = STOP;
                else if (lap)   state_nxt = RUN;
            end
            default: begin
                if (start_stop) state_nxt = RUN;
                else if (clear) state_nxt = IDLE;
            end
        endcase
    end

    // Ripple-carry BCD increment; seconds tens wraps at 5.
    always_comb begin
        inc  = cnt;
        wrap = 1'b0;
        if (cnt[0] != 4'd9) begin
            inc[0] = cnt[0] + 4'd1;
        end else begin
            inc[0] = 4'd0;
            if (cnt[1] != 4'd9) begin
                inc[1] = cnt[1] + 4'd1;
            end else begin
                inc[1] = 4'd0;
                if (cnt[2] != 4'd9) begin
                    inc[2] = cnt[2] + 4'd1;
                end else begin
                    inc[2] = 4'd0;
                    if (cnt[3] != 4'd5) begin
                        inc[3] = cnt[3] + 4'd1;
                    end else begin
                        inc[3] = 4'd0;
                        wrap   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            prescaler <= '0;
            cnt       <= '0;
            lap_reg   <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) lap_reg <= cnt;
            if (clr_now) begin
                prescaler <= '0;
                cnt       <= '0;
                overflow  <= 1'b0;
            end else if (counting) begin
                if (tick) begin
                    prescaler <= '0;
                    cnt       <= inc;
                    if (wrap) overflow <= 1'b1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    assign stopwatch  = (state == LAP) ? lap_reg[digit_idx] : cnt[digit_idx];
    assign running    = counting;
    assign lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd at DIV=4: vector table of pulse/advance
// records with hand-computed BCD readings, plus a mid-run reset sequence.
module tb_stopwatch_bcd;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [1:0] digit_idx;
    logic [3:0] stopwatch;
    logic       running;
    logic       lap_active;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    stopwatch_bcd #(.DIV(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .digit_idx  (digit_idx),
        .stopwatch  (stopwatch),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ss;
        logic        lp;
        logic        cl;
        int          n;
        logic [15:0] bcd;
        logic        run;
        logic        lapa;
        logic        ovf;
    } vec_t;

    vec_t vq[$];

    task automatic check_all(input string name, input logic [15:0] bcd,
                             input logic run, input logic lapa, input logic ovf);
        logic [3:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            digit_idx = 2'(i);
            #1;
            exp_d = bcd[4*i +: 4];
            checks++;
            if (stopwatch !== exp_d) begin
                errors++;
                $display("FAIL %s idx%0d: got %0d expected %0d", name, i, stopwatch, exp_d);
            end
        end
        checks++;
        if ({running, lap_active, overflow} !== {run, lapa, ovf}) begin
            errors++;
            $display("FAIL %s flags run/lap/ovf: got %b%b%b expected %b%b%b",
                     name, running, lap_active, overflow, run, lapa, ovf);
        end
    endtask

    // Pulses are presented for the first edge only; n edges total, then sample at negedge.
    task automatic apply(input logic ss, input logic lp, input logic cl, input int n);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_rst      = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        digit_idx  = 2'd0;

        //                name            ss    lp    cl    n      bcd        run   lapa  ovf
        vq.push_back('{"start",        1'b1, 1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"pre_tick",     1'b0, 1'b0, 1'b0, 3,     16'h0000, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"first_tick",   1'b0, 1'b0, 1'b0, 1,     16'h0001, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"edge40",       1'b0, 1'b0, 1'b0, 36,    16'h0010, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"at_0050",      1'b0, 1'b0, 1'b0, 160,   16'h0050, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"stop",         1'b1, 1'b0, 1'b0, 1,     16'h0050, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"stop_hold",    1'b0, 1'b0, 1'b0, 80,    16'h0050, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"clear",        1'b0, 1'b0, 1'b1, 1,     16'h0000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"idle_clear",   1'b0, 1'b0, 1'b1, 1,     16'h0000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"idle_lap",     1'b0, 1'b1, 1'b0, 1,     16'h0000, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"restart",      1'b1, 1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"run_clear",    1'b0, 1'b0, 1'b1, 8,     16'h0002, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"pre_p2",       1'b0, 1'b0, 1'b0, 2,     16'h0002, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"stop_p3",      1'b1, 1'b0, 1'b0, 1,     16'h0002, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"stop_hold2",   1'b0, 1'b0, 1'b0, 5,     16'h0002, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"ss_clr_stop",  1'b1, 1'b0, 1'b1, 1,     16'h0002, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"resume_tick",  1'b0, 1'b0, 1'b0, 1,     16'h0003, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"at_0123",      1'b0, 1'b0, 1'b0, 480,   16'h0123, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"lap_on",       1'b0, 1'b1, 1'b0, 1,     16'h0123, 1'b1, 1'b1, 1'b0});
        vq.push_back('{"lap_hold",     1'b0, 1'b0, 1'b0, 400,   16'h0123, 1'b1, 1'b1, 1'b0});
        vq.push_back('{"lap_off",      1'b0, 1'b1, 1'b0, 1,     16'h0223, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"ss_lap_run",   1'b1, 1'b1, 1'b0, 1,     16'h0223, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"rerun_p3",     1'b1, 1'b0, 1'b0, 1,     16'h0223, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"stop_on_tick", 1'b1, 1'b0, 1'b0, 1,     16'h0224, 1'b0, 1'b0, 1'b0});
        vq.push_back('{"rerun",        1'b1, 1'b0, 1'b0, 1,     16'h0224, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"at_0999",      1'b0, 1'b0, 1'b0, 3100,  16'h0999, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"carry_1000",   1'b0, 1'b0, 1'b0, 4,     16'h1000, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"at_5999",      1'b0, 1'b0, 1'b0, 19996, 16'h5999, 1'b1, 1'b0, 1'b0});
        vq.push_back('{"wrap",         1'b0, 1'b0, 1'b0, 4,     16'h0000, 1'b1, 1'b0, 1'b1});
        vq.push_back('{"after_wrap",   1'b0, 1'b0, 1'b0, 4,     16'h0001, 1'b1, 1'b0, 1'b1});
        vq.push_back('{"stop_ovf",     1'b1, 1'b0, 1'b0, 1,     16'h0001, 1'b0, 1'b0, 1'b1});
        vq.push_back('{"clear_ovf",    1'b0, 1'b0, 1'b1, 1,     16'h0000, 1'b0, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        foreach (vq[k]) begin
            apply(vq[k].ss, vq[k].lp, vq[k].cl, vq[k].n);
            check_all(vq[k].name, vq[k].bcd, vq[k].run, vq[k].lapa, vq[k].ovf);
        end

        // Reset mid-run, overriding coincident pulses; prescaler must restart from 0.
        apply(1'b1, 1'b0, 1'b0, 1);
        apply(1'b0, 1'b0, 1'b0, 10);
        check_all("mid_run", 16'h0002, 1'b1, 1'b0, 1'b0);
        n_rst      = 1'b0;
        start_stop = 1'b1;
        lap        = 1'b1;
        @(posedge clk);
        #1;
        n_rst      = 1'b1;
        start_stop = 1'b0;
        lap        = 1'b0;
        @(negedge clk);
        check_all("rst_mid_run", 16'h0000, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1);
        check_all("rst_idle_lap", 16'h0000, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1);
        check_all("rst_restart", 16'h0000, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 3);
        check_all("rst_pre_tick", 16'h0000, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1);
        check_all("rst_tick", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Four-digit BCD stopwatch core, format SS.hh, range 00.00 to 59.99.
- Sits directly upstream of the display output selector and drives its 4-bit stopwatch digit input.
- The downstream scan logic supplies a digit index; this block returns that digit combinationally.
- Provides start/stop, lap-hold and clear control from single-cycle button pulses.

Parameters:
DIV, 1000, clk cycles per hundredths increment; must be >= 1 (DIV=1 increments every counting cycle)

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  synchronous active-low reset
start_stop  input  1  one-cycle pulse: toggle run/stop
lap  input  1  one-cycle pulse: freeze/unfreeze displayed value while counting
clear  input  1  one-cycle pulse: zero count (effective only when stopped)
digit_idx  input  2  digit select: 0=hundredths, 1=tenths, 2=seconds units, 3=seconds tens
stopwatch  output  4  BCD value of selected digit
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
overflow  output  1  sticky: count wrapped 59.99 -> 00.00

Behaviour:
- Reset:
  - n_rst low at an edge forces state=IDLE, count=00.00, lap register=00.00, prescaler=0, overflow=0.
  - Resulting outputs: stopwatch=0 for any digit_idx, running=0, lap_active=0, overflow=0.
  - Reset overrides all pulses, including mid-count.
- States: IDLE, RUN, LAP, STOP. Counting occurs in RUN and LAP (registered state).
- Transitions:
  - Priority when pulses coincide: start_stop > lap > clear. Only pulses valid in the current state are considered.
  - IDLE: start_stop -> RUN. lap and clear are ignored.
  - RUN: start_stop -> STOP. lap -> LAP, capturing the current count into the lap register on that edge. clear is ignored.
  - LAP: start_stop -> STOP, display returns to live count. lap -> RUN, display returns to live count. clear is ignored.
  - STOP: start_stop -> RUN, prescaler resumes from its held value. clear -> IDLE, with count=00.00, prescaler=0, overflow=0. lap is ignored.
- Prescaler:
  - Counting, prescaler<DIV-1: prescaler+1.
  - Counting, prescaler==DIV-1: prescaler<=0 and count increments on the same edge.
  - Not counting: prescaler holds.
  - If a state-change edge coincides with prescaler==DIV-1 while counting, the increment still happens on that edge.
- Latency: start_stop registered at edge E0 with count 00.00, prescaler 0 -> count becomes 00.01 at edge E0+DIV.
- BCD arithmetic:
  - Each increment adds 1 to d0.
  - d0, d1, d2 wrap 9 -> 0 and carry up.
  - d3 wraps 5 -> 0.
  - Full rollover 59.99 -> 00.00 sets overflow=1. Counting continues. overflow holds until clear or reset.
  - No digit ever holds a non-BCD value.
- Output path:
  - stopwatch = digit[digit_idx] of the lap register when state==LAP, otherwise of the live count.
  - Purely combinational from registered data and digit_idx, zero-cycle latency.
- running and lap_active decode directly from the state register. No glitches across idx changes are required beyond the mux.
- Live count keeps advancing during LAP; the lap register changes only on RUN -> LAP.

Test Plan:
- Reset/first tick (DIV=4):
  - Reset, then pulse start_stop -> running=1 on the next cycle.
  - stopwatch(idx0)=0 until 4 edges after the start edge, then 1.
  - After 40 edges, idx1=1 and idx0=0.
- Carry chain (DIV=1):
  - Run to 09.99, one more edge -> idx3=1, idx2=0, idx1=0, idx0=0, overflow=0.
- Wrap (DIV=1):
  - Run from 00.00 for 6000 edges -> all digits 0, overflow=1, running=1.
  - Next edge -> idx0=1.
- Lap hold (DIV=1):
  - Pulse lap at count 01.23 -> lap_active=1.
  - After 100 more edges all idx still read 0,1,2,3 (idx3..0).
  - Pulse lap -> lap_active=0, display reads live 02.23 (plus elapsed increments).
- Stop/clear:
  - Stop at 00.50, wait 20*DIV cycles -> still 00.50, running=0.
  - Clear -> IDLE, all zeros, overflow=0.
  - Separately, clear pulsed during RUN -> ignored, count keeps advancing.
- Coincidence/reset:
  - start_stop+lap same cycle in RUN -> STOP, lap_active=0.
  - start_stop+clear in STOP -> RUN, count retained.
  - n_rst low mid-RUN -> next edge all outputs 0, state IDLE.
